// File: rtl/matmul_job_scheduler.sv
// Job sequencer for the systolic matmul. It validates a descriptor, pulses array_start, then issues one fetch per output tile.
// Each fetch is a valid/ready request that holds its addresses while stalled. Completion waits for results_done from the results controller.
module matmul_job_scheduler #(
    parameter int ARRAY_HEIGHT = 4,
    parameter int ARRAY_WIDTH  = 32,
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [15:0]           cfg_m,
    input  logic [15:0]           cfg_n,
    input  logic [15:0]           cfg_p,
    input  logic [ADDR_WIDTH-1:0] cfg_a_base,
    input  logic [ADDR_WIDTH-1:0] cfg_b_base,
    input  logic [ADDR_WIDTH-1:0] cfg_c_base,
    output logic [15:0]           m,
    output logic [15:0]           n,
    output logic [15:0]           p,
    output logic                  array_start,
    output logic                  fetch_valid,
    input  logic                  fetch_ready,
    output logic [ADDR_WIDTH-1:0] fetch_a_addr,
    output logic [ADDR_WIDTH-1:0] fetch_b_addr,
    output logic [ADDR_WIDTH-1:0] fetch_c_addr,
    input  logic                  results_done,
    output logic                  busy,
    output logic                  job_done,
    output logic                  job_error
);

    localparam logic [15:0] TILE_H = 16'(ARRAY_HEIGHT);
    localparam logic [15:0] TILE_W = 16'(ARRAY_WIDTH);
    localparam logic [15:0] H_MASK = 16'(ARRAY_HEIGHT - 1);
    localparam logic [15:0] W_MASK = 16'(ARRAY_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] BYTES = ADDR_WIDTH'(DATA_WIDTH / 8);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_START, S_FETCH, S_WAIT_DONE, S_DONE, S_ERR
    } state_t;

    state_t r_state, w_next;

    logic [15:0]           r_m, r_n, r_p, r_row, r_col;
    logic [ADDR_WIDTH-1:0] r_a_base, r_b_base, r_c_base;
    logic                  r_done_latch;

    logic w_cfg_hs, w_fetch_hs, w_reject, w_col_last, w_row_last, w_done_seen;
    logic [ADDR_WIDTH-1:0] w_row_ext, w_col_ext, w_n_ext, w_p_ext;

    assign w_cfg_hs    = cfg_valid && (r_state == S_IDLE);
    assign w_fetch_hs  = fetch_ready && (r_state == S_FETCH);
    assign w_reject    = (r_m == 16'd0) || (r_n == 16'd0) || (r_p == 16'd0) ||
                         ((r_m & H_MASK) != 16'd0) || ((r_p & W_MASK) != 16'd0);
    assign w_col_last  = (r_col + TILE_W) == r_p;
    assign w_row_last  = r_row == (r_m - TILE_H);
    assign w_done_seen = r_done_latch || results_done;

    // Row/col only move on an accepted fetch, so these stay stable under backpressure.
    assign w_row_ext    = ADDR_WIDTH'(r_row);
    assign w_col_ext    = ADDR_WIDTH'(r_col);
    assign w_n_ext      = ADDR_WIDTH'(r_n);
    assign w_p_ext      = ADDR_WIDTH'(r_p);
    assign fetch_a_addr = r_a_base + w_row_ext * w_n_ext * BYTES;
    assign fetch_b_addr = r_b_base + w_col_ext * BYTES;
    assign fetch_c_addr = r_c_base + (w_row_ext * w_p_ext + w_col_ext) * BYTES;

    assign m = r_m;
    assign n = r_n;
    assign p = r_p;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        cfg_ready   = 1'b0;
        array_start = 1'b0;
        fetch_valid = 1'b0;
        job_done    = 1'b0;
        job_error   = 1'b0;
        busy        = 1'b1;
        case (r_state)
            S_IDLE: begin
                cfg_ready = 1'b1;
                busy      = 1'b0;
                if (cfg_valid) w_next = S_CHECK;
            end
            S_CHECK: w_next = w_reject ? S_ERR : S_START;
            S_START: begin
                array_start = 1'b1;
                w_next      = S_FETCH;
            end
            S_FETCH: begin
                fetch_valid = 1'b1;
                if (fetch_ready && w_col_last && w_row_last) w_next = S_WAIT_DONE;
            end
            S_WAIT_DONE: if (w_done_seen) w_next = S_DONE;
            S_DONE: begin
                job_done = 1'b1;
                w_next   = S_IDLE;
            end
            S_ERR: begin
                job_error = 1'b1;
                w_next    = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_m          <= '0;
            r_n          <= '0;
            r_p          <= '0;
            r_row        <= '0;
            r_col        <= '0;
            r_a_base     <= '0;
            r_b_base     <= '0;
            r_c_base     <= '0;
            r_done_latch <= 1'b0;
        end else begin
            if (w_cfg_hs) begin
                r_m      <= cfg_m;
                r_n      <= cfg_n;
                r_p      <= cfg_p;
                r_a_base <= cfg_a_base;
                r_b_base <= cfg_b_base;
                r_c_base <= cfg_c_base;
            end
            if (r_state == S_START) begin
                r_row <= '0;
                r_col <= '0;
            end else if (w_fetch_hs) begin
                if (w_col_last) begin
                    r_col <= '0;
                    if (!w_row_last) r_row <= r_row + TILE_H;
                end else begin
                    r_col <= r_col + TILE_W;
                end
            end
            // The results controller may finish before the last fetch is accepted.
            if (r_state == S_WAIT_DONE && w_done_seen)
                r_done_latch <= 1'b0;
            else if ((r_state == S_FETCH || r_state == S_WAIT_DONE) && results_done)
                r_done_latch <= 1'b1;
        end
    end

endmodule

// File: tb/tb_matmul_job_scheduler.sv
// Directed bench for matmul_job_scheduler: nominal job, backpressure, rejects, early done, reset mid-job, back-to-back.
module tb_matmul_job_scheduler;

    logic        clk = 1'b0;
    logic        reset, cfg_valid, cfg_ready, fetch_ready, results_done;
    logic [15:0] cfg_m, cfg_n, cfg_p, m, n, p;
    logic [31:0] cfg_a_base, cfg_b_base, cfg_c_base;
    logic [31:0] fetch_a_addr, fetch_b_addr, fetch_c_addr;
    logic        array_start, fetch_valid, busy, job_done, job_error;

    always #5 clk = ~clk;

    matmul_job_scheduler #(
        .ARRAY_HEIGHT(4), .ARRAY_WIDTH(32), .DATA_WIDTH(16), .ADDR_WIDTH(32)
    ) dut (
        .clk(clk), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_m(cfg_m), .cfg_n(cfg_n), .cfg_p(cfg_p),
        .cfg_a_base(cfg_a_base), .cfg_b_base(cfg_b_base), .cfg_c_base(cfg_c_base),
        .m(m), .n(n), .p(p),
        .array_start(array_start),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
        .fetch_a_addr(fetch_a_addr), .fetch_b_addr(fetch_b_addr), .fetch_c_addr(fetch_c_addr),
        .results_done(results_done),
        .busy(busy), .job_done(job_done), .job_error(job_error)
    );

    int errors = 0;
    int checks = 0;

    int n_start, n_fetch, n_done, n_err, n_fv, n_accept, n_stall, n_unstable, done_fetch;
    logic [31:0] fa[8], fb[8], fc[8];
    logic [31:0] pa, pb, pc;
    logic        prev_stall;
    logic [31:0] exp_a[4], exp_b[4], exp_c[4];

    logic bp_mode = 1'b0;
    int   bp_cnt  = 0;

    // Observer on the falling edge; counts pulses and records accepted fetches.
    always @(negedge clk) begin
        if (!reset) begin
            if (array_start) n_start++;
            if (fetch_valid) n_fv++;
            if (fetch_valid && prev_stall &&
                (fetch_a_addr !== pa || fetch_b_addr !== pb || fetch_c_addr !== pc))
                n_unstable++;
            prev_stall = fetch_valid && !fetch_ready;
            pa = fetch_a_addr; pb = fetch_b_addr; pc = fetch_c_addr;
            if (fetch_valid && !fetch_ready) n_stall++;
            if (fetch_valid && fetch_ready) begin
                if (n_fetch < 8) begin
                    fa[n_fetch] = fetch_a_addr;
                    fb[n_fetch] = fetch_b_addr;
                    fc[n_fetch] = fetch_c_addr;
                end
                n_fetch++;
            end
            if (job_done) begin
                n_done++;
                done_fetch = n_fetch;
            end
            if (job_error) n_err++;
            if (cfg_valid && cfg_ready) n_accept++;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // fetch_ready high one cycle in three while bp_mode is set.
    always @(posedge clk) begin
        if (bp_mode) begin
            #1;
            bp_cnt      = (bp_cnt + 1) % 3;
            fetch_ready = (bp_cnt == 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        n_start = 0; n_fetch = 0; n_done = 0; n_err = 0; n_fv = 0;
        n_accept = 0; n_stall = 0; n_unstable = 0; done_fetch = 0;
        prev_stall = 1'b0;
    endtask

    task automatic run_job(input logic [15:0] jm, input logic [15:0] jn, input logic [15:0] jp,
                           input int done_at, output int done_iter);
        cfg_m = jm; cfg_n = jn; cfg_p = jp;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        done_iter = -1;
        for (int i = 0; i < 200; i++) begin
            results_done = (i == done_at);
            tick();
            if (n_done != 0 || n_err != 0) begin
                done_iter = i;
                break;
            end
        end
        results_done = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++; if (cfg_ready !== 1'b1)   begin errors++; $display("FAIL reset_cfg_ready got=%b exp=1", cfg_ready); end
        checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_fetch_valid got=%b exp=0", fetch_valid); end
        checks++; if (array_start !== 1'b0) begin errors++; $display("FAIL reset_array_start got=%b exp=0", array_start); end
        checks++; if (job_done !== 1'b0 || job_error !== 1'b0)
            begin errors++; $display("FAIL reset_pulses got=%b%b exp=00", job_done, job_error); end
        checks++; if (m !== 16'd0 || n !== 16'd0 || p !== 16'd0)
            begin errors++; $display("FAIL reset_mnp got=%0d/%0d/%0d exp=0/0/0", m, n, p); end
    endtask

    task automatic check_addrs(input string tag);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (fa[k] !== exp_a[k] || fb[k] !== exp_b[k] || fc[k] !== exp_c[k]) begin
                errors++;
                $display("FAIL %s_tile%0d got=%h/%h/%h exp=%h/%h/%h", tag, k,
                         fa[k], fb[k], fc[k], exp_a[k], exp_b[k], exp_c[k]);
            end
        end
    endtask

    task automatic test_nominal();
        int it;
        clear_mon();
        fetch_ready = 1'b1;
        run_job(16'd8, 16'd5, 16'd64, 20, it);
        checks++; if (it !== 21)      begin errors++; $display("FAIL nom_done_cycle got=%0d exp=21", it); end
        checks++; if (n_start !== 1)  begin errors++; $display("FAIL nom_array_start got=%0d exp=1", n_start); end
        checks++; if (n_fetch !== 4)  begin errors++; $display("FAIL nom_fetch_count got=%0d exp=4", n_fetch); end
        check_addrs("nom");
        tick();
        checks++; if (n_done !== 1)   begin errors++; $display("FAIL nom_job_done got=%0d exp=1", n_done); end
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL nom_busy_after got=%b exp=0", busy); end
    endtask

    task automatic test_backpressure();
        int it;
        clear_mon();
        bp_cnt  = 0;
        bp_mode = 1'b1;
        run_job(16'd8, 16'd5, 16'd64, 20, it);
        bp_mode = 1'b0;
        tick();
        fetch_ready = 1'b1;
        checks++; if (it < 0)            begin errors++; $display("FAIL bp_timeout got=%0d exp>=0", it); end
        checks++; if (n_fetch !== 4)     begin errors++; $display("FAIL bp_fetch_count got=%0d exp=4", n_fetch); end
        check_addrs("bp");
        checks++; if (n_stall == 0)      begin errors++; $display("FAIL bp_stalls got=%0d exp>0", n_stall); end
        checks++; if (n_unstable !== 0)  begin errors++; $display("FAIL bp_addr_stable got=%0d exp=0", n_unstable); end
        checks++; if (n_done !== 1 || done_fetch !== 4)
            begin errors++; $display("FAIL bp_done got=%0d@%0d exp=1@4", n_done, done_fetch); end
    endtask

    task automatic test_bad_descriptors();
        logic [15:0] bm[3], bn[3], bp[3];
        int it;
        bm[0] = 16'd6; bn[0] = 16'd5; bp[0] = 16'd64;
        bm[1] = 16'd8; bn[1] = 16'd0; bp[1] = 16'd64;
        bm[2] = 16'd8; bn[2] = 16'd5; bp[2] = 16'd48;
        fetch_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            clear_mon();
            run_job(bm[k], bn[k], bp[k], -1, it);
            tick();
            checks++; if (it !== 1)       begin errors++; $display("FAIL bad%0d_err_cycle got=%0d exp=1", k, it); end
            checks++; if (n_err !== 1)    begin errors++; $display("FAIL bad%0d_err_pulse got=%0d exp=1", k, n_err); end
            checks++; if (n_start !== 0 || n_fv !== 0 || n_done !== 0)
                begin errors++; $display("FAIL bad%0d_side got=%0d/%0d/%0d exp=0/0/0", k, n_start, n_fv, n_done); end
        end
    endtask

    task automatic test_early_done();
        int it;
        clear_mon();
        fetch_ready = 1'b1;
        run_job(16'd8, 16'd5, 16'd64, 3, it);
        checks++; if (it !== 7)          begin errors++; $display("FAIL early_done_cycle got=%0d exp=7", it); end
        checks++; if (done_fetch !== 4)  begin errors++; $display("FAIL early_done_fetches got=%0d exp=4", done_fetch); end
        tick();
        checks++; if (n_done !== 1)      begin errors++; $display("FAIL early_done_count got=%0d exp=1", n_done); end
    endtask

    task automatic test_reset_mid_job();
        int it;
        clear_mon();
        fetch_ready = 1'b1;
        cfg_m = 16'd8; cfg_n = 16'd5; cfg_p = 16'd64;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        for (int i = 0; i < 50 && n_fetch == 0; i++) tick();
        checks++; if (n_fetch !== 1) begin errors++; $display("FAIL rst_mid_first_fetch got=%0d exp=1", n_fetch); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (busy !== 1'b0 || fetch_valid !== 1'b0 || cfg_ready !== 1'b1)
            begin errors++; $display("FAIL rst_mid_state got=%b%b%b exp=001", busy, fetch_valid, cfg_ready); end
        checks++; if (m !== 16'd0) begin errors++; $display("FAIL rst_mid_m got=%0d exp=0", m); end
        tick(); tick(); tick();
        checks++; if (n_done !== 0) begin errors++; $display("FAIL rst_mid_no_done got=%0d exp=0", n_done); end
        clear_mon();
        run_job(16'd4, 16'd1, 16'd32, 5, it);
        checks++; if (it !== 6)      begin errors++; $display("FAIL rst_job2_done_cycle got=%0d exp=6", it); end
        checks++; if (n_fetch !== 1) begin errors++; $display("FAIL rst_job2_fetches got=%0d exp=1", n_fetch); end
        checks++; if (fa[0] !== 32'h1000 || fb[0] !== 32'h2000 || fc[0] !== 32'h3000)
            begin errors++; $display("FAIL rst_job2_addr got=%h/%h/%h exp=1000/2000/3000", fa[0], fb[0], fc[0]); end
        tick();
    endtask

    task automatic test_back_to_back();
        clear_mon();
        fetch_ready  = 1'b1;
        results_done = 1'b1;
        cfg_m = 16'd4; cfg_n = 16'd1; cfg_p = 16'd32;
        cfg_valid = 1'b1;
        tick();
        cfg_m = 16'd8; cfg_n = 16'd5; cfg_p = 16'd64;
        for (int i = 0; i < 50 && n_done == 0; i++) tick();
        checks++; if (n_accept !== 1) begin errors++; $display("FAIL b2b_accept_busy got=%0d exp=1", n_accept); end
        checks++; if (m !== 16'd4)    begin errors++; $display("FAIL b2b_m_held got=%0d exp=4", m); end
        tick();
        checks++; if (n_accept !== 2) begin errors++; $display("FAIL b2b_accept_next got=%0d exp=2", n_accept); end
        checks++; if (m !== 16'd8)    begin errors++; $display("FAIL b2b_m_next got=%0d exp=8", m); end
        cfg_valid = 1'b0;
        for (int i = 0; i < 100 && n_done < 2; i++) tick();
        results_done = 1'b0;
        checks++; if (n_done !== 2 || n_fetch !== 5)
            begin errors++; $display("FAIL b2b_second_job got=%0d/%0d exp=2/5", n_done, n_fetch); end
        checks++; if (n_accept !== 2) begin errors++; $display("FAIL b2b_accept_total got=%0d exp=2", n_accept); end
        tick();
    endtask

    initial begin
        reset = 1'b1; cfg_valid = 1'b0; fetch_ready = 1'b0; results_done = 1'b0;
        cfg_m = '0; cfg_n = '0; cfg_p = '0;
        cfg_a_base = 32'h1000; cfg_b_base = 32'h2000; cfg_c_base = 32'h3000;
        exp_a[0] = 32'h1000; exp_b[0] = 32'h2000; exp_c[0] = 32'h3000;
        exp_a[1] = 32'h1000; exp_b[1] = 32'h2040; exp_c[1] = 32'h3040;
        exp_a[2] = 32'h1028; exp_b[2] = 32'h2000; exp_c[2] = 32'h3200;
        exp_a[3] = 32'h1028; exp_b[3] = 32'h2040; exp_c[3] = 32'h3240;
        clear_mon();
        test_reset();
        test_nominal();
        test_backpressure();
        test_bad_descriptors();
        test_early_done();
        test_reset_mid_job();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
